// File: rtl/xtea_stream_pkg.sv
// Shared definitions for the tagged XTEA plaintext byte stream (tx and rx sides).
package xtea_stream_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned TAG_W       = 2;
  localparam int unsigned WORD_W      = 10;

  typedef logic [127:0] block_t;

  typedef struct packed {
    logic [1:0] tag;
    logic [7:0] data;
  } tagged_byte_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/blk_out_reg.sv
// Single-entry valid/ready output register; drops a new block when still full.
module blk_out_reg
  import xtea_stream_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_load,
  input  block_t i_data,
  input  logic   i_ready,
  output block_t o_data,
  output logic   o_valid,
  output logic   o_ovf
);

  block_t r_data;
  logic   r_valid;
  logic   r_ovf;
  logic   w_space;

  // Slot is free when empty or being drained this very cycle.
  assign w_space = ~r_valid | i_ready;

  // Load / accept / overflow decision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (i_load) begin
        if (w_space) begin
          r_data  <= i_data;
          r_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/ip_enc_rx.sv
// Tagged byte-stream receiver: checks rolling tags, assembles 16-byte blocks.
module ip_enc_rx
  import xtea_stream_pkg::*;
#(
  parameter int unsigned GAP_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              req,
  output block_t            blk_out,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              busy,
  output logic              tag_err,
  output logic              tmo_err,
  output logic              ovf_err
);

  localparam int unsigned GAP_W    = 8;
  localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_MAX);
  localparam logic [3:0]       LAST_IDX = 4'(BLOCK_BYTES - 1);

  rx_state_e         r_state;
  logic [14:0][7:0]  r_asm;
  logic [3:0]        r_idx;
  logic [GAP_W-1:0]  r_gap;
  logic              r_busy;
  logic              r_tag_err;
  logic              r_tmo_err;

  tagged_byte_t      w_word;
  logic              w_tag_ok;
  logic              w_complete;
  logic [3:0]        w_slot;
  logic [GAP_W-1:0]  w_gap_next;
  block_t            w_block;

  // Word decode and completion detect for the output register.
  assign w_word     = tagged_byte_t'(data_in);
  assign w_tag_ok   = (w_word.tag == r_idx[1:0]);
  assign w_slot     = 4'(4'd14 - r_idx);
  assign w_gap_next = GAP_W'(r_gap + GAP_W'(1));
  assign w_complete = (r_state == COLLECT) && req && w_tag_ok && (r_idx == LAST_IDX);
  assign w_block    = {r_asm, w_word.data};

  // Receive FSM: tag sequencing, byte assembly, gap timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_asm     <= '0;
      r_idx     <= '0;
      r_gap     <= '0;
      r_busy    <= 1'b0;
      r_tag_err <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tag_err <= 1'b0;
      r_tmo_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            if (w_word.tag == 2'd0) begin
              r_asm[14] <= w_word.data;
              r_idx     <= 4'd1;
              r_gap     <= '0;
              r_busy    <= 1'b1;
              r_state   <= COLLECT;
            end else begin
              r_tag_err <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (req) begin
            r_gap <= '0;
            if (w_tag_ok) begin
              if (r_idx == LAST_IDX) begin
                r_idx   <= '0;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end else begin
                r_asm[w_slot] <= w_word.data;
                r_idx         <= 4'(r_idx + 4'd1);
              end
            end else begin
              // A stray tag 0 is treated as the start of a new block.
              r_tag_err <= 1'b1;
              if (w_word.tag == 2'd0) begin
                r_asm[14] <= w_word.data;
                r_idx     <= 4'd1;
              end else begin
                r_idx   <= '0;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end
          end else if (w_gap_next == GAP_LIM) begin
            r_tmo_err <= 1'b1;
            r_gap     <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_gap <= w_gap_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  blk_out_reg u_blk_out_reg (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_complete),
    .i_data  (w_block),
    .i_ready (blk_ready),
    .o_data  (blk_out),
    .o_valid (blk_valid),
    .o_ovf   (ovf_err)
  );

  assign busy    = r_busy;
  assign tag_err = r_tag_err;
  assign tmo_err = r_tmo_err;

endmodule

// File: tb/tb_ip_enc_rx.sv
// Bench for ip_enc_rx: queue-based reference model plus directed literal checks.
module tb_ip_enc_rx;
  import xtea_stream_pkg::*;

  localparam int unsigned GAP = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [9:0]   data_in = '0;
  logic         req = 1'b0;
  logic         blk_ready = 1'b1;
  block_t       blk_out;
  logic         blk_valid, busy, tag_err, tmo_err, ovf_err;

  int n_vec = 0;
  int n_bad = 0;

  ip_enc_rx #(.GAP_MAX(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .req       (req),
    .blk_out   (blk_out),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .busy      (busy),
    .tag_err   (tag_err),
    .tmo_err   (tmo_err),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a block is just a list of bytes whose length gives the next tag.
  logic [7:0] m_q[$];
  bit         m_in, m_valid, m_tag, m_tmo, m_ovf;
  int         m_gap;
  block_t     m_out;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_in = 0; m_valid = 0; m_tag = 0; m_tmo = 0; m_ovf = 0;
      m_gap = 0; m_out = '0;
    end else begin
      bit     done;
      bit     was_valid;
      block_t blk;
      logic [1:0] t;
      logic [7:0] d;
      done = 0; blk = '0;
      m_tag = 0; m_tmo = 0; m_ovf = 0;
      was_valid = m_valid;
      t = data_in[9:8];
      d = data_in[7:0];
      if (req) begin
        m_gap = 0;
        if (!m_in) begin
          if (t == 2'd0) begin m_q.delete(); m_q.push_back(d); m_in = 1; end
          else m_tag = 1;
        end else if (int'(t) == (m_q.size() % 4)) begin
          m_q.push_back(d);
          if (m_q.size() == 16) begin
            foreach (m_q[i]) blk = {blk[119:0], m_q[i]};
            done = 1;
            m_q.delete();
            m_in = 0;
          end
        end else begin
          m_tag = 1;
          m_q.delete();
          if (t == 2'd0) m_q.push_back(d);
          else m_in = 0;
        end
      end else if (m_in) begin
        m_gap++;
        if (m_gap == GAP) begin
          m_tmo = 1; m_in = 0; m_gap = 0; m_q.delete();
        end
      end
      if (done) begin
        if (!was_valid || blk_ready) begin m_out = blk; m_valid = 1; end
        else m_ovf = 1;
      end else if (was_valid && blk_ready) begin
        m_valid = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  bit run_cmp = 0;
  always @(posedge clk) begin
    #1;
    if (run_cmp) begin
      chk("m_blk_out",   blk_out,   m_out);
      chk("m_blk_valid", 128'(blk_valid), 128'(m_valid));
      chk("m_busy",      128'(busy),      128'(m_in));
      chk("m_tag_err",   128'(tag_err),   128'(m_tag));
      chk("m_tmo_err",   128'(tmo_err),   128'(m_tmo));
      chk("m_ovf_err",   128'(ovf_err),   128'(m_ovf));
    end
  end

  task automatic send(input logic [1:0] t, input logic [7:0] d);
    @(negedge clk);
    req = 1'b1;
    data_in = {t, d};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  // Send bytes 0..n-1 of a block with the rolling tag sequence.
  task automatic send_block(input block_t b, input int n);
    block_t tmp;
    tmp = b;
    for (int i = 0; i < n; i++) begin
      send(2'(i % 4), tmp[127:120]);
      tmp = tmp << 8;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_blk_out"}, blk_out, '0);
    chk({nm, "_valid"}, 128'(blk_valid), 128'd0);
    chk({nm, "_busy"}, 128'(busy), 128'd0);
    chk({nm, "_errs"}, 128'({tag_err, tmo_err, ovf_err}), 128'd0);
  endtask

  localparam block_t NOM = 128'hA5A5A5A501234567FEDCBA985A5A5A5A;
  localparam block_t RSY = 128'h11202122232425262728292A2B2C2D2E;
  localparam block_t BA  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam block_t BB  = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam block_t BC  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam block_t BD  = 128'hDEADBEEFCAFEF00D1234567887654321;

  initial begin
    block_t rs;
    #3;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_cmp = 1;

    // Nominal block.
    blk_ready = 1'b1;
    send_block(NOM, 16);
    after_edge();
    chk("nom_blk", blk_out, NOM);
    chk("nom_valid", 128'(blk_valid), 128'd1);
    chk("nom_busy", 128'(busy), 128'd0);
    idle(2);

    // Bad tag 2 at idx 5 -> back to idle.
    send_block(BA, 5);
    send(2'd2, 8'h77);
    after_edge();
    chk("bad_tag_pulse", 128'(tag_err), 128'd1);
    chk("bad_tag_busy", 128'(busy), 128'd0);
    idle(1);

    // Tag 0 at idx 7 resynchronises; 15 more bytes complete a block starting with 11.
    send_block(BB, 7);
    send(2'd0, 8'h11);
    after_edge();
    chk("resync_pulse", 128'(tag_err), 128'd1);
    chk("resync_busy", 128'(busy), 128'd1);
    rs = RSY << 8;
    for (int i = 1; i < 16; i++) begin
      send(2'(i % 4), rs[127:120]);
      rs = rs << 8;
    end
    after_edge();
    chk("resync_blk", blk_out, RSY);
    chk("resync_valid", 128'(blk_valid), 128'd1);
    idle(2);

    // Gap of GAP-1 cycles is tolerated.
    send_block(BC, 6);
    idle(GAP - 1);
    rs = BC << 48;
    for (int i = 6; i < 16; i++) begin
      send(2'(i % 4), rs[127:120]);
      rs = rs << 8;
    end
    after_edge();
    chk("gap_ok_blk", blk_out, BC);
    chk("gap_ok_valid", 128'(blk_valid), 128'd1);
    idle(2);

    // Gap of GAP cycles aborts.
    send_block(BD, 5);
    idle(GAP);
    @(posedge clk); #2;
    chk("tmo_pulse", 128'(tmo_err), 128'd1);
    chk("tmo_busy", 128'(busy), 128'd0);
    chk("tmo_valid", 128'(blk_valid), 128'd0);
    idle(2);

    // Overflow: consumer stalled over two back-to-back blocks.
    blk_ready = 1'b0;
    send_block(BA, 16);
    send_block(BB, 16);
    after_edge();
    chk("ovf_pulse", 128'(ovf_err), 128'd1);
    chk("ovf_held_blk", blk_out, BA);
    chk("ovf_held_valid", 128'(blk_valid), 128'd1);
    idle(2);
    blk_ready = 1'b1;
    idle(1);
    blk_ready = 1'b0;

    // Ready raised exactly on the completion edge: new block loads, no overflow.
    send_block(BC, 16);
    send_block(BD, 15);
    send(2'd3, BD[7:0]);
    blk_ready = 1'b1;
    after_edge();
    chk("swap_blk", blk_out, BD);
    chk("swap_valid", 128'(blk_valid), 128'd1);
    chk("swap_no_ovf", 128'(ovf_err), 128'd0);
    blk_ready = 1'b0;
    idle(2);

    // Asynchronous reset mid-block with a held block.
    send_block(BA, 9);
    @(negedge clk);
    req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    idle(2);
    reset = 1'b1;
    blk_ready = 1'b1;
    send_block(NOM, 16);
    after_edge();
    chk("post_rst_blk", blk_out, NOM);
    chk("post_rst_valid", 128'(blk_valid), 128'd1);
    idle(3);

    run_cmp = 0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ip_enc_rx.md
# ip_enc_rx

Receive-side counterpart of the tagged byte stream used to feed plaintext into the XTEA encryption datapath. Samples 10-bit `{tag[1:0], byte[7:0]}` words qualified by `req`, checks the rolling 2-bit tag sequence, and reassembles 16 bytes (MSB first) into a 128-bit block. Completed blocks go to the cipher core over a valid/ready handshake. Tag, gap-timeout and overflow faults are reported as one-cycle pulses.

## Interface
- `GAP_MAX`, default 16: consecutive idle (`req`=0) cycles tolerated inside a block before it is aborted; legal range 1..255.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `data_in` in 10: `{tag[1:0], byte[7:0]}`. Only sampled when `req`=1.
- `req` in 1: word-valid strobe. There is no back-pressure, so every `req` cycle is one word.
- `blk_out` out 128: assembled block; byte 0 occupies bits [127:120].
- `blk_valid` out 1: `blk_out` holds an unconsumed block.
- `blk_ready` in 1: consumer accepts the block when `blk_valid`&`blk_ready`.
- `busy` out 1: a partial block is in progress (state COLLECT).
- `tag_err` out 1: one-cycle pulse on a tag-sequence violation.
- `tmo_err` out 1: one-cycle pulse when a block is aborted by the gap timeout.
- `ovf_err` out 1: one-cycle pulse when a completed block is dropped because the output register is still full.

## Operation
- **Storage:** assembly register (120 bits, bytes 0..14), byte index `idx[3:0]`, gap counter, output register plus `blk_valid`.
- **FSM states:** IDLE, COLLECT.
- **IDLE:**
  - `req` with tag=0: store the byte at index 0, set `idx`=1, go to COLLECT.
  - `req` with tag≠0: pulse `tag_err`, stay in IDLE, drop the byte.
- **COLLECT, `req`=1:** the expected tag is `idx[1:0]`.
  - Tag matches and `idx`<15: store the byte at bits [127-8·idx -: 8], increment `idx`, clear the gap counter.
  - Tag matches and `idx`=15: the block completes (see the output rules below), then go to IDLE.
  - Tag mismatches: pulse `tag_err` and discard the partial block. If the offending tag is 0, it resynchronises: the byte is stored as index 0, `idx`=1, stay in COLLECT. Otherwise go to IDLE.
- **COLLECT, `req`=0:** increment the gap counter. When it reaches `GAP_MAX`, pulse `tmo_err`, discard the partial block and go to IDLE.
- **Output register:**
  - A completed block is loaded as `{assembly, last byte}` when `blk_valid`=0, or when `blk_valid`&`blk_ready` in the same cycle. The load sets `blk_valid`.
  - Otherwise the completed block is dropped, `ovf_err` pulses, and the output register and `blk_valid` are unchanged.
- **Handshake:** `blk_valid` stays high and `blk_out` stays stable until accepted. Acceptance without a simultaneous load clears `blk_valid`.
- **Error pulses:** at most one error pulses per cycle; the rules above are mutually exclusive.

## Timing
- **Reset values:** while `reset`=0, every output is 0 (`blk_out`, `blk_valid`, `busy`, all error pulses), state is IDLE, and `idx` and the gap counter are 0. Reset mid-block or with `blk_valid`=1 loses that data silently, with no error pulse.
- **Latency:** if the 16th byte is sampled at edge E, `blk_valid`=1 and `blk_out` are valid immediately after E.
- **Back-to-back blocks:** 16 consecutive `req` cycles per block; no dead cycle is required between blocks.
- **Error pulses:** registered; high for exactly the one cycle after the triggering edge.
- **`busy`:** high from the edge that accepts byte 0 until the edge that completes or aborts the block.
- **Gap timeout:** `req` low for exactly `GAP_MAX`−1 cycles, then high, continues the block. `GAP_MAX` consecutive low cycles abort it.

## Structure
- Shared package `xtea_stream_pkg` holds:
  - `BLOCK_BYTES`=16, `TAG_W`=2, `WORD_W`=10
  - `typedef logic [127:0] block_t`
  - `typedef struct packed {logic [1:0] tag; logic [7:0] data;} tagged_byte_t`
  - the state enum `rx_state_e {IDLE, COLLECT}`
- The transmit generator reuses the same package.
- One natural sub-module, `blk_out_reg`: the single-entry valid/ready output register with its load/accept/overflow decision. Everything else stays in `ip_enc_rx`.

## Test plan
- **Nominal block:** stream A5,A5,A5,A5,01,23,45,67,FE,DC,BA,98,5A,5A,5A,5A with tags 0,1,2,3 repeating and `blk_ready`=1 → one cycle of `blk_valid` with `blk_out`=A5A5A5A501234567FEDCBA985A5A5A5A, no error pulses.
- **Resync:** bad tag 2 at `idx`=5 → `tag_err` pulse and return to IDLE. Tag-0 byte 11 at `idx`=7 → `tag_err`, restart with `idx`=1; 15 further good bytes produce a block whose top byte is 11.
- **Gap timeout:** `GAP_MAX`=4. A 3-cycle gap mid-block → block completes normally. A 4-cycle gap → `tmo_err` pulse, `busy`=0, no `blk_valid`.
- **Overflow and handshake:** `blk_ready`=0 over two back-to-back blocks → first block held stable, second dropped with `ovf_err`. Raise `blk_ready` exactly on the second block's completion edge → second block loaded, no `ovf_err`.
- **Reset mid-block:** drive `reset`=0 asynchronously mid-cycle at `idx`=9 with `blk_valid`=1 → all outputs 0 immediately. After release, a fresh 16-byte block assembles correctly.
